// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: state encoding and default timing constants for the clock-gating controller
package clk_gate_pkg;
    typedef enum logic [1:0] {
        OFF   = 2'b00,
        WAKE  = 2'b01,
        ON    = 2'b10,
        DRAIN = 2'b11
    } state_t;
    localparam int IDLE_CYCLES_DEF = 16;
    localparam int WAKE_CYCLES_DEF = 2;
    localparam int CNT_W_DEF       = 8;
endpackage

// File: rtl/clk_gate_cell.sv
// clk_gate_cell: latch-based glitch-free clock gate, isolated so a library ICG can replace it
module clk_gate_cell (
    input  logic CLK,
    input  logic RST,
    input  logic En,
    output logic Gated_CLK
);
    logic en_lat;
    // Transparent only while CLK is low, so enable changes land on the next rising edge
    always_latch
        if (!RST) en_lat <= 1'b0;
        else if (!CLK) en_lat <= En;
    assign Gated_CLK = CLK & en_lat;
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: wake/idle/drain controller driving a glitch-free gated clock
// Optional CLK_GATE_TEST_EN adds Test_En, which forces the gated clock to run in every state.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Wake_Req,
    input  logic             Busy,
    input  logic             Sleep_Req,
`ifdef CLK_GATE_TEST_EN
    input  logic             Test_En,
`endif
    output logic             Gated_CLK,
    output logic             Clk_En,
    output logic             Ack,
    output logic             Sleeping,
    output logic [CNT_W-1:0] Idle_Cnt
);
    state_t           state;
    logic [CNT_W-1:0] wake_cnt;
    logic             idle;
    logic             at_max;
    logic             gate_en;
    assign idle   = !Busy && !Wake_Req;
    assign at_max = Idle_Cnt == CNT_W'(IDLE_CYCLES - 1);
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state    <= OFF;
            wake_cnt <= '0;
            Idle_Cnt <= '0;
            Clk_En   <= 1'b0;
            Ack      <= 1'b0;
            Sleeping <= 1'b1;
        end else begin
            case (state)
                OFF:
                    if (Wake_Req) begin
                        state    <= WAKE;
                        wake_cnt <= CNT_W'(WAKE_CYCLES - 1);
                        Clk_En   <= 1'b1;
                        Sleeping <= 1'b0;
                    end
                WAKE:
                    if (wake_cnt == '0) begin
                        state <= ON;
                        Ack   <= 1'b1;
                    end else
                        wake_cnt <= wake_cnt - 1'b1;
                ON:
                    // Wake_Req or Busy keeps the domain running; Sleep_Req only shortcuts the idle timeout
                    if (idle && (Sleep_Req || at_max)) begin
                        state    <= DRAIN;
                        Ack      <= 1'b0;
                        Idle_Cnt <= '0;
                    end else
                        Idle_Cnt <= !idle ? '0 : at_max ? Idle_Cnt : Idle_Cnt + 1'b1;
                DRAIN:
                    if (Wake_Req) begin
                        state <= ON;
                        Ack   <= 1'b1;
                    end else begin
                        state    <= OFF;
                        Clk_En   <= 1'b0;
                        Sleeping <= 1'b1;
                    end
                default: state <= OFF;
            endcase
        end
`ifdef CLK_GATE_TEST_EN
    assign gate_en = Clk_En | Test_En;
`else
    assign gate_en = Clk_En;
`endif
    clk_gate_cell u_cell (
        .CLK       (CLK),
        .RST       (RST),
        .En        (gate_en),
        .Gated_CLK (Gated_CLK)
    );
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed self-checking bench for clk_gate_ctrl (IDLE_CYCLES=16, WAKE_CYCLES=2)
module tb_clk_gate_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Wake_Req = 1'b0;
    logic       Busy = 1'b0;
    logic       Sleep_Req = 1'b0;
    logic       Gated_CLK;
    logic       Clk_En;
    logic       Ack;
    logic       Sleeping;
    logic [7:0] Idle_Cnt;
`ifdef CLK_GATE_TEST_EN
    logic       Test_En = 1'b0;
`endif
    int n_chk = 0;
    int n_pass = 0;
    int gcnt = 0;
    int g0;

    always #5 CLK = ~CLK;
    always @(posedge Gated_CLK) gcnt++;

    clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .CNT_W(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Wake_Req  (Wake_Req),
        .Busy      (Busy),
        .Sleep_Req (Sleep_Req),
`ifdef CLK_GATE_TEST_EN
        .Test_En   (Test_En),
`endif
        .Gated_CLK (Gated_CLK),
        .Clk_En    (Clk_En),
        .Ack       (Ack),
        .Sleeping  (Sleeping),
        .Idle_Cnt  (Idle_Cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Pulse Wake_Req for one cycle and land on the first ON cycle
    task automatic wake_up();
        Wake_Req = 1'b1;
        tick(1);
        Wake_Req = 1'b0;
        tick(2);
        check("wake_ack", Ack, 1);
        check("wake_idle0", Idle_Cnt, 0);
    endtask

    initial begin
        tick(3);
        check("rst_clk_en", Clk_En, 0);
        check("rst_ack", Ack, 0);
        check("rst_sleeping", Sleeping, 1);
        check("rst_idle", Idle_Cnt, 0);
        RST = 1'b1;
        g0 = gcnt;
        tick(20);
        check("off_clk_en", Clk_En, 0);
        check("off_sleeping", Sleeping, 1);
        check("off_flat", gcnt - g0, 0);

        Wake_Req = 1'b1;
        g0 = gcnt;
        tick(1);
        Wake_Req = 1'b0;
        check("wake_clk_en", Clk_En, 1);
        check("wake_ack_low", Ack, 0);
        check("wake_sleeping", Sleeping, 0);
        check("wake_no_edge_yet", gcnt - g0, 0);
        @(posedge CLK);
        #1 check("gclk_high_early", Gated_CLK, 1);
        #3 check("gclk_high_late", Gated_CLK, 1);
        @(negedge CLK);
        check("wake_first_edge", gcnt - g0, 1);
        check("wake_ack_still_low", Ack, 0);
        tick(1);
        check("on_ack", Ack, 1);
        for (int k = 0; k < 16; k++) begin
            check("idle_count", Idle_Cnt, k);
            tick(1);
        end
        check("drain_ack", Ack, 0);
        check("drain_clk_en", Clk_En, 1);
        check("drain_idle", Idle_Cnt, 0);
        check("drain_sleeping", Sleeping, 0);
        tick(1);
        check("timeout_off_clk_en", Clk_En, 0);
        check("timeout_off_sleeping", Sleeping, 1);
        g0 = gcnt;
        tick(5);
        check("timeout_gclk_stopped", gcnt - g0, 0);

        wake_up();
        tick(10);
        check("busy_pre_idle", Idle_Cnt, 10);
        Busy = 1'b1;
        tick(1);
        check("busy_clears_idle", Idle_Cnt, 0);
        Busy = 1'b0;
        tick(15);
        check("restart_idle15", Idle_Cnt, 15);
        check("restart_still_on", Ack, 1);
        tick(1);
        check("restart_drain_ack", Ack, 0);
        check("restart_drain_clk_en", Clk_En, 1);
        tick(1);
        check("restart_off", Sleeping, 1);

        wake_up();
        Busy = 1'b1;
        Sleep_Req = 1'b1;
        tick(5);
        check("sleep_busy_ack", Ack, 1);
        check("sleep_busy_clk_en", Clk_En, 1);
        Busy = 1'b0;
        tick(1);
        check("sleep_drain_ack", Ack, 0);
        check("sleep_drain_clk_en", Clk_En, 1);
        Sleep_Req = 1'b0;
        Wake_Req = 1'b1;
        tick(1);
        check("drain_rewake_ack", Ack, 1);
        check("drain_rewake_sleeping", Sleeping, 0);
        check("drain_rewake_clk_en", Clk_En, 1);
        Sleep_Req = 1'b1;
        tick(3);
        check("wake_beats_sleep", Ack, 1);
        check("wake_beats_sleep_slp", Sleeping, 0);
        Wake_Req = 1'b0;
        tick(1);
        check("late_sleep_drain", Ack, 0);
        Sleep_Req = 1'b0;
        tick(1);
        check("late_sleep_off", Sleeping, 1);
        check("late_sleep_clk_en", Clk_En, 0);

        Wake_Req = 1'b1;
        tick(1);
        Wake_Req = 1'b0;
        @(posedge CLK);
        #2 check("rst_wake_gclk_pre", Gated_CLK, 1);
        RST = 1'b0;
        #1 check("rst_wake_clk_en", Clk_En, 0);
        check("rst_wake_gclk", Gated_CLK, 0);
        check("rst_wake_sleeping", Sleeping, 1);
        @(negedge CLK);
        RST = 1'b1;
        tick(1);
        check("rst_wake_after_off", Clk_En, 0);

        wake_up();
        tick(3);
        @(posedge CLK);
        #2 check("rst_on_gclk_pre", Gated_CLK, 1);
        RST = 1'b0;
        #1 check("rst_on_ack", Ack, 0);
        check("rst_on_clk_en", Clk_En, 0);
        check("rst_on_gclk", Gated_CLK, 0);
        check("rst_on_idle", Idle_Cnt, 0);
        @(negedge CLK);
        RST = 1'b1;
        g0 = gcnt;
        tick(3);
        check("rst_on_after_sleeping", Sleeping, 1);
        check("rst_on_after_flat", gcnt - g0, 0);

`ifdef CLK_GATE_TEST_EN
        Test_En = 1'b1;
        g0 = gcnt;
        tick(4);
        check("test_en_toggles", gcnt - g0, 4);
        check("test_en_sleeping", Sleeping, 1);
        check("test_en_ack", Ack, 0);
        Test_En = 1'b0;
        g0 = gcnt;
        tick(3);
        check("test_en_off_flat", gcnt - g0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
